// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared types and defaults for the PLL reset/power-up sequencer
package pll_rst_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_FILTER,
        S_RST_HOLD,
        S_PWR_WAIT,
        S_INIT_REQ,
        S_RUN
    } seq_state_t;

    localparam int LOCK_FILT_DEF = 64;
    localparam int RST_HOLD_DEF  = 16;
    localparam int PWR_CYC_DEF   = 5400;
    localparam int CNT_W_DEF     = 13;

    localparam logic [7:0] LOSS_MAX = 8'hFF;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop single-bit synchronizer, resets to 0
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL lock filter, system reset and SDRAM power-up sequencer
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int LOCK_FILT = LOCK_FILT_DEF,
    parameter int RST_HOLD  = RST_HOLD_DEF,
    parameter int PWR_CYC   = PWR_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       init_done,
    output logic       sys_rst_n,
    output logic       init_req,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] FILT_LD = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(PWR_CYC - 1);

    logic             lk_s;
    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       loss_n;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_WAIT_LOCK;
            cnt           <= '0;
            lock_loss_cnt <= 8'd0;
            sys_rst_n     <= 1'b0;
            init_req      <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            lock_loss_cnt <= loss_n;
            // Outputs decode the next state so they change on the same edge as the state.
            sys_rst_n     <= (state_n == S_PWR_WAIT) || (state_n == S_INIT_REQ) ||
                             (state_n == S_RUN);
            init_req      <= (state_n == S_INIT_REQ);
            ready         <= (state_n == S_RUN);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        loss_n  = lock_loss_cnt;

        // Lock loss overrides counter expiry and init_done everywhere.
        if ((state != S_WAIT_LOCK) && !lk_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
            if ((state == S_RUN) && (lock_loss_cnt != LOSS_MAX)) begin
                loss_n = lock_loss_cnt + 8'd1;
            end
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_n = S_FILTER;
                        cnt_n   = FILT_LD;
                    end
                end
                S_FILTER: begin
                    if (cnt == '0) begin
                        state_n = S_RST_HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_RST_HOLD: begin
                    if (cnt == '0) begin
                        state_n = S_PWR_WAIT;
                        cnt_n   = PWR_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_PWR_WAIT: begin
                    if (cnt == '0) begin
                        state_n = S_INIT_REQ;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_INIT_REQ: begin
                    if (init_done) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    state_n = S_RUN;
                end
                default: begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Clock-domain reset and power-up sequencer sitting directly downstream of the SDRAM PLL. It consumes the PLL's asynchronous `locked` flag in the 27 MHz output-clock domain, filters it, generates the synchronous system reset for the SDRAM controller, and enforces the SDRAM 200 µs power-up wait. After that wait it hands off to the controller's init sequence via a request/done handshake. It also counts lock-loss events for debug.

## Interface
Parameters:
- `LOCK_FILT`, 64: consecutive cycles synchronized `locked` must be high before sequencing starts.
- `RST_HOLD`, 16: cycles `sys_rst_n` is held low after the filter passes.
- `PWR_CYC`, 5400: power-up wait cycles; 200 µs at 27 MHz.
- `CNT_W`, 13: shared down-counter width; must satisfy 2^CNT_W > max(LOCK_FILT, RST_HOLD, PWR_CYC).

Ports:
- `clk`  in  1  PLL output clock (27 MHz).
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain only.
- `pll_locked`  in  1  PLL lock flag; asynchronous to `clk`.
- `init_done`  in  1  SDRAM init sequence complete; level, synchronous to `clk`.
- `sys_rst_n`  out  1  synchronous active-low reset to downstream logic.
- `init_req`  out  1  request to start SDRAM init; level, held until `init_done`.
- `ready`  out  1  sequencing complete, system running.
- `lock_loss_cnt`  out  8  saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `lk_s`. No other logic samples `pll_locked` directly.
- FSM states and transitions:
  - WAIT_LOCK: when `lk_s`=1, load counter with LOCK_FILT-1 and go to FILTER.
  - FILTER: decrement the counter. If `lk_s`=0, return to WAIT_LOCK. When the counter reaches 0 with `lk_s`=1, load RST_HOLD-1 and go to RST_HOLD.
  - RST_HOLD: decrement. At 0, load PWR_CYC-1 and go to PWR_WAIT.
  - PWR_WAIT: decrement. At 0, go to INIT_REQ.
  - INIT_REQ: wait for `init_done`=1, then go to RUN.
  - RUN: terminal while `lk_s`=1.
- Lock loss: `lk_s`=0 in any state other than WAIT_LOCK causes WAIT_LOCK on the next edge. This has priority over all other transitions, including counter expiry and `init_done`.
  - Leaving RUN this way increments `lock_loss_cnt`, saturating at 255.
  - Leaving any other state does not increment it.
- Output decode (all registered):
  - `sys_rst_n`=1 only in PWR_WAIT, INIT_REQ and RUN.
  - `init_req`=1 only in INIT_REQ.
  - `ready`=1 only in RUN.
- `init_done` is ignored outside INIT_REQ. If it is already high on INIT_REQ entry, RUN follows on the next edge.

## Timing
- Reset values: state WAIT_LOCK, counter 0, synchronizer 0, `sys_rst_n`=0, `init_req`=0, `ready`=0, `lock_loss_cnt`=0.
- Reset mid-operation returns to these values immediately (asynchronous).
- `pll_locked` rise to FILTER entry: 3 edges (2 synchronizer + 1 FSM).
- FILTER dwell: LOCK_FILT cycles. RST_HOLD dwell: RST_HOLD cycles. PWR_WAIT dwell: PWR_CYC cycles.
- With `init_done` already high, total from `pll_locked` rise to `ready`=1 is 3 + LOCK_FILT + RST_HOLD + PWR_CYC + 1 edges.
- `pll_locked` fall to `sys_rst_n`/`ready`/`init_req` low: 3 edges.
- `lock_loss_cnt` updates on the same edge that enters WAIT_LOCK.
- Glitch on `lk_s` during FILTER: FILTER restarts from WAIT_LOCK with a full LOCK_FILT reload.

## Structure
- Package `pll_rst_pkg`:
  - FSM state enum: WAIT_LOCK, FILTER, RST_HOLD, PWR_WAIT, INIT_REQ, RUN.
  - Default parameter constants.
  - `LOSS_MAX`=8'hFF.
- Sub-module `sync2`: generic 2-FF bit synchronizer with async active-low reset to 0. Instantiated once for `pll_locked`.
- One shared down-counter, reloaded on each state entry.

## Test plan
Run with LOCK_FILT=4, RST_HOLD=3, PWR_CYC=10.
- Reset release, `pll_locked` rises at cycle 0, `init_done` tied high:
  - `sys_rst_n` rises at edge 10.
  - `ready` rises at edge 21.
  - `init_req` high for exactly 1 cycle.
- `pll_locked` low for 1 cycle in the middle of FILTER: FSM returns to WAIT_LOCK, total delay extends accordingly, `lock_loss_cnt` stays 0.
- In INIT_REQ, hold `init_done` low for 50 cycles then raise it: `init_req` stays high the full 50 cycles, `ready` rises 1 edge after `init_done`.
- In RUN, drop `pll_locked`:
  - `ready` and `sys_rst_n` go low 3 edges later.
  - `lock_loss_cnt` becomes 1.
  - Relock repeats the full sequence.
- Force 300 RUN→loss cycles: `lock_loss_cnt` saturates at 255.
- Assert `rst_n` low during PWR_WAIT: all outputs go to reset values immediately, and the sequence restarts from WAIT_LOCK after release.
